s2_rr_arb: RTL and testbench

S2_RR_ARB -- requirements
Module: s2_rr_arb

---
 rtl/s2_rr_arb.sv | 110 +++++++++++
 tb/tb_s2_rr_arb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/s2_rr_arb.sv
// Four-source round-robin burst arbiter driving the S2 mux/register stage.
// Grants, selects and S2 output tags are all registered.
module s2_rr_arb #(
  parameter int MAX_BEATS = 8
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] req,
  input  logic [3:0] last,
  output logic [3:0] gnt,
  output logic       A1,
  output logic       B1,
  output logic       A0,
  output logic       B0,
  output logic       out_valid,
  output logic [1:0] out_src,
  output logic       busy
);

  localparam int BW = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [1:0]    owner;
  logic [1:0]    last_owner;
  logic [1:0]    sel;
  logic [BW-1:0] beat;

  logic          done;
  logic [3:0]    cand;
  logic [1:0]    win_idle;
  logic [1:0]    win_next;

  // First asserted bit searching ptr+1, ptr+2, ptr+3, then ptr itself.
  function automatic logic [1:0] rr_pick(
    input logic [1:0] ptr,
    input logic [3:0] r
  );
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // Owner only competes again when its burst was cut by the beat limit.
  always_comb begin
    done = last[owner] | ~req[owner]
         | (beat == BW'(MAX_BEATS));
    cand = req;
    if (last[owner]) cand[owner] = 1'b0;
  end

  assign win_idle = rr_pick(last_owner, req);
  assign win_next = rr_pick(owner, cand);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state      <= IDLE;
      owner      <= 2'd0;
      last_owner <= 2'd3;
      sel        <= 2'd0;
      beat       <= '0;
      gnt        <= 4'b0;
      out_valid  <= 1'b0;
      out_src    <= 2'd0;
    end else begin
      out_valid <= |gnt;
      out_src   <= owner;
      unique case (state)
        IDLE: begin
          if (|req) begin
            state <= GRANT;
            owner <= win_idle;
            sel   <= win_idle;
            gnt   <= 4'b1 << win_idle;
            beat  <= BW'(1);
          end
        end
        GRANT: begin
          if (done) begin
            last_owner <= owner;
            if (|cand) begin
              owner <= win_next;
              sel   <= win_next;
              gnt   <= 4'b1 << win_next;
              beat  <= BW'(1);
            end else begin
              state <= IDLE;
              gnt   <= 4'b0;
              beat  <= '0;
            end
          end else begin
            beat <= beat + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign A1   = sel[1];
  assign B1   = sel[1];
  assign A0   = sel[0];
  assign B0   = sel[0];
  assign busy = (state == GRANT);

endmodule

// File: tb/tb_s2_rr_arb.sv
// Bench for s2_rr_arb: reference model feeds a per-cycle scoreboard,
// scenario tasks add directed checks.
module tb_s2_rr_arb;

  localparam int MB = 8;

  logic       CLK;
  logic       CLR;
  logic [3:0] req;
  logic [3:0] last;
  logic [3:0] gnt;
  logic       A1, B1, A0, B0;
  logic       out_valid;
  logic [1:0] out_src;
  logic       busy;

  int checks = 0;
  int errs   = 0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic       ov;
    logic [1:0] os;
    logic       b;
  } exp_t;

  exp_t sbq[$];

  bit         m_busy;
  int         m_own;
  int         m_ptr;
  int         m_beat;
  logic [3:0] m_gnt;
  logic [1:0] m_sel;
  logic       m_ov;
  logic [1:0] m_os;

  s2_rr_arb #(.MAX_BEATS(MB)) dut (
    .CLK(CLK), .CLR(CLR), .req(req), .last(last),
    .gnt(gnt), .A1(A1), .B1(B1), .A0(A0), .B0(B0),
    .out_valid(out_valid), .out_src(out_src), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int m_rr(int ptr, logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_ptr = 3; m_beat = 0;
    m_gnt = 4'b0; m_sel = 2'd0; m_ov = 1'b0; m_os = 2'd0;
    sbq.delete();
  endtask

  task automatic model_step(output exp_t e);
    int w;
    logic [3:0] r;
    m_ov = (m_gnt != 4'b0);
    m_os = 2'(m_own);
    if (!m_busy) begin
      w = m_rr(m_ptr, req);
      if (w >= 0) begin
        m_busy = 1; m_own = w; m_beat = 1;
      end
    end else if (last[m_own] || !req[m_own] || m_beat == MB) begin
      m_ptr = m_own;
      r = req;
      if (last[m_own]) r[m_own] = 1'b0;
      w = m_rr(m_ptr, r);
      if (w >= 0) begin
        m_own = w; m_beat = 1;
      end else begin
        m_busy = 0; m_beat = 0;
      end
    end else begin
      m_beat++;
    end
    m_gnt = m_busy ? (4'b1 << m_own) : 4'b0;
    if (m_busy) m_sel = 2'(m_own);
    e.g = m_gnt; e.s = m_sel; e.ov = m_ov;
    e.os = m_os; e.b = m_busy;
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] l);
    exp_t e;
    req = r; last = l;
    model_step(e);
    sbq.push_back(e);
    @(posedge CLK); #1;
    e = sbq.pop_front();
    checks++;
    if (gnt !== e.g || {A1, A0} !== e.s || {B1, B0} !== e.s
        || out_valid !== e.ov || out_src !== e.os || busy !== e.b) begin
      errs++;
      $display("FAIL step t=%0t gnt=%b/%b sel=%b%b%b%b/%b ov=%b/%b os=%0d/%0d busy=%b/%b",
               $time, gnt, e.g, A1, B1, A0, B0, e.s, out_valid, e.ov,
               out_src, e.os, busy, e.b);
    end
  endtask

  task automatic apply_clr(input string tag);
    CLR = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0 || {A1, B1, A0, B0} !== 4'b0 || out_valid !== 1'b0
        || out_src !== 2'd0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s gnt=%b sel=%b%b%b%b ov=%b os=%0d busy=%b want all zero",
               tag, gnt, A1, B1, A0, B0, out_valid, out_src, busy);
    end
    @(posedge CLK); #1;
    CLR = 1'b0;
    req = 4'b0; last = 4'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_clr("reset_state");
    step(4'b0, 4'b0);
    step(4'b0, 4'b1111);
  endtask

  task automatic test_rr_all();
    logic [3:0] want [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_clr("reset_rr");
    for (int i = 1; i <= 34; i++) begin
      step(4'b1111, 4'b0);
      if ((i - 1) % 8 == 0 && (i - 1) / 8 < 5) begin
        checks++;
        if (gnt !== want[(i - 1) / 8]) begin
          errs++;
          $display("FAIL rr_order cycle %0d gnt=%b want %b", i, gnt, want[(i - 1) / 8]);
        end
      end
    end
    step(4'b0, 4'b0);
    step(4'b0, 4'b0);
  endtask

  task automatic test_last_single();
    apply_clr("reset_last");
    step(4'b0100, 4'b0);
    checks++;
    if (gnt !== 4'b0100 || {A1, B1, A0, B0} !== 4'b1100) begin
      errs++;
      $display("FAIL last_grant gnt=%b sel=%b%b%b%b want 0100 1100", gnt, A1, B1, A0, B0);
    end
    step(4'b0, 4'b0100);
    checks++;
    if (gnt !== 4'b0 || out_valid !== 1'b1 || out_src !== 2'd2 || busy !== 1'b0) begin
      errs++;
      $display("FAIL last_end gnt=%b ov=%b os=%0d busy=%b want 0000 1 2 0",
               gnt, out_valid, out_src, busy);
    end
    step(4'b0, 4'b0);
    checks++;
    if ({A1, B1, A0, B0} !== 4'b1100) begin
      errs++;
      $display("FAIL idle_sel_hold sel=%b%b%b%b want 1100", A1, B1, A0, B0);
    end
  endtask

  task automatic test_drop();
    apply_clr("reset_drop");
    step(4'b1010, 4'b0);
    step(4'b1010, 4'b0);
    step(4'b1010, 4'b0);
    checks++;
    if (gnt !== 4'b0010) begin
      errs++;
      $display("FAIL drop_third gnt=%b want 0010", gnt);
    end
    step(4'b1000, 4'b0);
    checks++;
    if (gnt !== 4'b1000 || out_src !== 2'd1) begin
      errs++;
      $display("FAIL drop_switch gnt=%b os=%0d want 1000 1", gnt, out_src);
    end
    step(4'b1000, 4'b1000);
    checks++;
    if (out_src !== 2'd3) begin
      errs++;
      $display("FAIL drop_src os=%0d want 3", out_src);
    end
    step(4'b0, 4'b0);
  endtask

  task automatic test_sole_max();
    apply_clr("reset_sole");
    for (int i = 1; i <= 20; i++) begin
      step(4'b0001, 4'b0);
      checks++;
      if (gnt !== 4'b0001 || busy !== 1'b1) begin
        errs++;
        $display("FAIL sole_cont cycle %0d gnt=%b busy=%b want 0001 1", i, gnt, busy);
      end
    end
    step(4'b0, 4'b0);
  endtask

  task automatic test_clr_mid();
    apply_clr("reset_mid");
    for (int i = 0; i < 4; i++) step(4'b0100, 4'b0);
    #2;
    apply_clr("clr_midburst");
    step(4'b1111, 4'b0);
    checks++;
    if (gnt !== 4'b0001) begin
      errs++;
      $display("FAIL clr_ptr gnt=%b want 0001", gnt);
    end
    step(4'b0, 4'b0);
  endtask

  task automatic test_last_other();
    apply_clr("reset_other");
    step(4'b0010, 4'b0);
    for (int i = 2; i <= 9; i++) begin
      step(4'b0010, 4'b1000);
      checks++;
      if (gnt !== 4'b0010) begin
        errs++;
        $display("FAIL last_other cycle %0d gnt=%b want 0010", i, gnt);
      end
    end
    step(4'b0, 4'b0);
  endtask

  task automatic test_random();
    apply_clr("reset_rand");
    for (int i = 0; i < 300; i++)
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15) & 4'($urandom_range(0, 15))));
    step(4'b0, 4'b0);
  endtask

  initial begin
    CLR = 1'b1; req = 4'b0; last = 4'b0;
    model_reset();
    @(posedge CLK); #1;
    test_reset();
    test_rr_all();
    test_last_single();
    test_drop();
    test_sole_max();
    test_clr_mid();
    test_last_other();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
